// File: rtl/proc_pkg.sv
// Shared definitions for the multicycle bus-based processor control path:
// opcode and ALU encodings, the control FSM state type and BusSel offsets.
package proc_pkg;

  // Instruction opcodes (IR[IR_W-1 -: 3])
  localparam logic [2:0] OP_MV  = 3'd0;
  localparam logic [2:0] OP_MVI = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_OR  = 3'd4;
  localparam logic [2:0] OP_SLT = 3'd5;
  localparam logic [2:0] OP_SLL = 3'd6;
  localparam logic [2:0] OP_SRL = 3'd7;

  // ALU operation encodings driven on AluOp
  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_OR  = 3'd2;
  localparam logic [2:0] ALU_SLT = 3'd3;
  localparam logic [2:0] ALU_SLL = 3'd4;
  localparam logic [2:0] ALU_SRL = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T0   = 3'd1,
    ST_T1   = 3'd2,
    ST_T2   = 3'd3,
    ST_T3   = 3'd4
  } state_e;

  // BusSel bit of the G register, directly above the Rk sources
  function automatic int unsigned g_idx(input int unsigned nreg);
    return nreg;
  endfunction

  // BusSel bit of the external data input
  function automatic int unsigned din_idx(input int unsigned nreg);
    return nreg + 1;
  endfunction

  // Opcode to ALU operation; non-ALU opcodes map to ADD
  function automatic logic [2:0] alu_op_of(input logic [2:0] opc);
    logic [2:0] op;
    case (opc)
      OP_SUB:  op = ALU_SUB;
      OP_OR:   op = ALU_OR;
      OP_SLT:  op = ALU_SLT;
      OP_SLL:  op = ALU_SLL;
      OP_SRL:  op = ALU_SRL;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/onehot_dec.sv
// Enable-gated binary to one-hot decoder.
//   en_i     : 1 = drive the selected bit, 0 = all outputs low
//   idx_i    : AW-bit index
//   onehot_o : 2**AW one-hot (or all-zero) vector
module onehot_dec #(
  parameter  int unsigned AW = 3,
  localparam int unsigned N  = 1 << AW
) (
  input  logic          en_i,
  input  logic [AW-1:0] idx_i,
  output logic [N-1:0]  onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) onehot_o[idx_i] = 1'b1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Control FSM for the multicycle bus-based processor. Fetches an instruction
// into an internal IR and sequences mv/mvi/add/sub/or/slt/sll/srl over up to
// four timesteps. Outputs are Moore-decoded from the state and IR.
//   Clock, Resetn : rising-edge clock, async active-low reset
//   Run           : start request, sampled in IDLE and in retire cycles
//   DIN           : instruction word {opc[2:0], X, Y}
//   IRin          : IR load strobe (T0)
//   Rin           : one-hot register write-enable
//   BusSel        : one-hot bus source ([NREG-1:0]=Rk, [NREG]=G, [NREG+1]=DIN)
//   Ain, Gin      : A / G register write-enables
//   AluOp         : ALU operation, zero unless Gin
//   Done          : one-cycle retire pulse
//   Busy          : high outside IDLE
module multicycle_ctrl
  import proc_pkg::*;
#(
  parameter  int unsigned NREG     = 8,
  parameter  bit          SHIFT_EN = 1'b1,
  localparam int unsigned REG_AW   = $clog2(NREG),
  localparam int unsigned IR_W     = 3 + 2 * REG_AW
) (
  input  logic            Clock,
  input  logic            Resetn,
  input  logic            Run,
  input  logic [IR_W-1:0] DIN,
  output logic            IRin,
  output logic [NREG-1:0] Rin,
  output logic [NREG+1:0] BusSel,
  output logic            Ain,
  output logic            Gin,
  output logic [2:0]      AluOp,
  output logic            Done,
  output logic            Busy
);

  localparam int unsigned G_IDX   = g_idx(NREG);
  localparam int unsigned DIN_IDX = din_idx(NREG);

  state_e            state_q, state_d;
  logic [IR_W-1:0]   ir_q, ir_d;
  logic [2:0]        opc;
  logic [REG_AW-1:0] rx, ry;
  logic [NREG-1:0]   x_oh, y_oh;
  logic              is_nop;

  assign opc = ir_q[IR_W-1 -: 3];
  assign rx  = ir_q[2*REG_AW-1 -: REG_AW];
  assign ry  = ir_q[REG_AW-1:0];

  // Shifts retire without touching the datapath when the shifter is absent
  assign is_nop = ((opc == OP_SLL) || (opc == OP_SRL)) && !SHIFT_EN;

  onehot_dec #(.AW(REG_AW)) u_dec_x (
    .en_i     (1'b1),
    .idx_i    (rx),
    .onehot_o (x_oh)
  );

  onehot_dec #(.AW(REG_AW)) u_dec_y (
    .en_i     (1'b1),
    .idx_i    (ry),
    .onehot_o (y_oh)
  );

  // State and instruction register
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q <= ST_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Next state and Moore output decode
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    IRin    = 1'b0;
    Rin     = '0;
    BusSel  = '0;
    Ain     = 1'b0;
    Gin     = 1'b0;
    AluOp   = ALU_ADD;
    Done    = 1'b0;
    Busy    = (state_q != ST_IDLE);

    case (state_q)
      ST_IDLE: begin
        if (Run) state_d = ST_T0;
      end
      ST_T0: begin
        IRin    = 1'b1;
        ir_d    = DIN;
        state_d = ST_T1;
      end
      ST_T1: begin
        case (opc)
          OP_MV: begin
            BusSel[NREG-1:0] = y_oh;
            Rin              = x_oh;
            Done             = 1'b1;
          end
          OP_MVI: begin
            BusSel[DIN_IDX] = 1'b1;
            Rin             = x_oh;
            Done            = 1'b1;
          end
          default: begin
            if (is_nop) begin
              Done = 1'b1;
            end else begin
              BusSel[NREG-1:0] = x_oh;
              Ain              = 1'b1;
              state_d          = ST_T2;
            end
          end
        endcase
      end
      ST_T2: begin
        BusSel[NREG-1:0] = y_oh;
        Gin              = 1'b1;
        AluOp            = alu_op_of(opc);
        state_d          = ST_T3;
      end
      ST_T3: begin
        BusSel[G_IDX] = 1'b1;
        Rin           = x_oh;
        Done          = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Retire cycle: back-to-back issue when Run is already up
    if (Done) state_d = Run ? ST_T0 : ST_IDLE;
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: three configurations (8 regs with shifter,
// 8 regs without shifter, 16 regs with shifter) run in lockstep against a
// per-instruction schedule model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [8:0]  din_a, din_b;
  logic [10:0] din_c;

  always #5 clk = ~clk;

  logic        irin_a, ain_a, gin_a, done_a, busy_a;
  logic [7:0]  rin_a;
  logic [9:0]  bus_a;
  logic [2:0]  alu_a;
  logic        irin_b, ain_b, gin_b, done_b, busy_b;
  logic [7:0]  rin_b;
  logic [9:0]  bus_b;
  logic [2:0]  alu_b;
  logic        irin_c, ain_c, gin_c, done_c, busy_c;
  logic [15:0] rin_c;
  logic [17:0] bus_c;
  logic [2:0]  alu_c;

  multicycle_ctrl #(.NREG(8), .SHIFT_EN(1'b1)) u_a (
    .Clock(clk), .Resetn(rst_n), .Run(run), .DIN(din_a),
    .IRin(irin_a), .Rin(rin_a), .BusSel(bus_a), .Ain(ain_a), .Gin(gin_a),
    .AluOp(alu_a), .Done(done_a), .Busy(busy_a)
  );

  multicycle_ctrl #(.NREG(8), .SHIFT_EN(1'b0)) u_b (
    .Clock(clk), .Resetn(rst_n), .Run(run), .DIN(din_b),
    .IRin(irin_b), .Rin(rin_b), .BusSel(bus_b), .Ain(ain_b), .Gin(gin_b),
    .AluOp(alu_b), .Done(done_b), .Busy(busy_b)
  );

  multicycle_ctrl #(.NREG(16), .SHIFT_EN(1'b1)) u_c (
    .Clock(clk), .Resetn(rst_n), .Run(run), .DIN(din_c),
    .IRin(irin_c), .Rin(rin_c), .BusSel(bus_c), .Ain(ain_c), .Gin(gin_c),
    .AluOp(alu_c), .Done(done_c), .Busy(busy_c)
  );

  typedef struct packed {
    logic        irin;
    logic [15:0] rin;
    logic [17:0] bus;
    logic        ain;
    logic        gin;
    logic [2:0]  aluop;
    logic        done;
    logic        busy;
  } vec_t;

  // Expected output sequence of the instruction in flight, per instance
  vec_t sch [3][4];
  int   len [3];
  int   pos [3];
  int   nreg_of [3] = '{8, 8, 16};
  bit   shen_of [3] = '{1'b1, 1'b0, 1'b1};
  // ALU code per opcode (mv, mvi unused)
  int   alu_tab [8] = '{0, 0, 0, 1, 2, 3, 4, 5};

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic vec_t observed(input int i);
    vec_t v;
    case (i)
      0:       v = {irin_a, 16'(rin_a), 18'(bus_a), ain_a, gin_a, alu_a, done_a, busy_a};
      1:       v = {irin_b, 16'(rin_b), 18'(bus_b), ain_b, gin_b, alu_b, done_b, busy_b};
      default: v = {irin_c, rin_c, bus_c, ain_c, gin_c, alu_c, done_c, busy_c};
    endcase
    return v;
  endfunction

  function automatic vec_t expected(input int i);
    return (pos[i] < len[i]) ? sch[i][pos[i]] : vec_t'('0);
  endfunction

  function automatic int din_of(input int i);
    case (i)
      0:       return int'(din_a);
      1:       return int'(din_b);
      default: return int'(din_c);
    endcase
  endfunction

  task automatic start(input int i);
    vec_t v;
    v      = '0;
    v.irin = 1'b1;
    v.busy = 1'b1;
    sch[i][0] = v;
    len[i] = 1;
    pos[i] = 0;
  endtask

  // Expand a fetched instruction into its remaining cycles
  task automatic expand(input int i, input int din);
    int   rb, nreg, opc, x, y;
    vec_t v;
    nreg = nreg_of[i];
    rb   = $clog2(nreg);
    opc  = (din >> (2 * rb)) & 7;
    x    = (din >> rb) % nreg;
    y    = din % nreg;
    v      = '0;
    v.busy = 1'b1;
    if (opc == 0) begin
      v.bus = 18'(1) << y;  v.rin = 16'(1) << x;  v.done = 1'b1;
      sch[i][1] = v;  len[i] = 2;
    end else if (opc == 1) begin
      v.bus = 18'(1) << (nreg + 1);  v.rin = 16'(1) << x;  v.done = 1'b1;
      sch[i][1] = v;  len[i] = 2;
    end else if (opc >= 6 && !shen_of[i]) begin
      v.done = 1'b1;
      sch[i][1] = v;  len[i] = 2;
    end else begin
      v.bus = 18'(1) << x;  v.ain = 1'b1;
      sch[i][1] = v;
      v = '0;  v.busy = 1'b1;
      v.bus = 18'(1) << y;  v.gin = 1'b1;  v.aluop = 3'(alu_tab[opc]);
      sch[i][2] = v;
      v = '0;  v.busy = 1'b1;
      v.bus = 18'(1) << nreg;  v.rin = 16'(1) << x;  v.done = 1'b1;
      sch[i][3] = v;
      len[i] = 4;
    end
    pos[i] = 1;
  endtask

  // Advance every model by one clock edge using the inputs the DUTs sampled
  task automatic model_edge();
    vec_t cur;
    for (int i = 0; i < 3; i++) begin
      if (pos[i] < len[i]) begin
        cur = sch[i][pos[i]];
        if (cur.irin) expand(i, din_of(i));
        else if (cur.done) begin
          if (run) start(i);
          else begin len[i] = 0; pos[i] = 0; end
        end else pos[i]++;
      end else if (run) begin
        start(i);
      end
    end
  endtask

  task automatic compare_all(input string ph);
    for (int i = 0; i < 3; i++)
      chk($sformatf("%s_dut%0d", ph, i), 64'(observed(i)), 64'(expected(i)));
  endtask

  task automatic tick(input logic r, input logic [8:0] a, input logic [8:0] b, input logic [10:0] c);
    run   = r;
    din_a = a;
    din_b = b;
    din_c = c;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all("cyc");
  endtask

  // Same 9-bit instruction to all three, register fields widened for 16 regs
  task automatic tick9(input logic r, input logic [8:0] d);
    tick(r, d, d, {d[8:6], 1'b0, d[5:3], 1'b0, d[2:0]});
  endtask

  task automatic hard_reset();
    #2 rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin len[i] = 0; pos[i] = 0; end
    #1 compare_all("rst_now");
    @(negedge clk);
    compare_all("rst_hold");
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    run   = 1'b0;
    din_a = '0;
    din_b = '0;
    din_c = '0;
    for (int i = 0; i < 3; i++) begin len[i] = 0; pos[i] = 0; end
    @(negedge clk);
    compare_all("reset");
    rst_n = 1'b1;

    // mv R2,R5 / shift NOP / srl R9,R2
    tick(1'b1, 9'b000_010_101, 9'b110_011_001, {3'b111, 4'd9, 4'd2});
    tick(1'b0, 9'b000_010_101, 9'b110_011_001, {3'b111, 4'd9, 4'd2});
    for (int k = 0; k < 4; k++)
      tick(1'b0, 9'b000_010_101, 9'b110_011_001, {3'b111, 4'd9, 4'd2});

    // mvi R7
    tick9(1'b1, 9'b001_111_000);
    for (int k = 0; k < 3; k++) tick9(1'b0, 9'b001_111_000);

    // sub R1,R3
    tick9(1'b1, 9'b011_001_011);
    for (int k = 0; k < 5; k++) tick9(1'b0, 9'b011_001_011);

    // add R4,R6 then mv R0,R0 back-to-back with Run held high
    for (int k = 0; k < 5; k++) tick9(1'b1, 9'b010_100_110);
    tick9(1'b1, 9'b000_000_000);
    tick9(1'b0, 9'b000_000_000);
    tick9(1'b0, 9'b000_000_000);

    // reset during T2 of an add, then idle with Run low
    tick9(1'b1, 9'b010_011_101);
    tick9(1'b0, 9'b010_011_101);
    tick9(1'b0, 9'b010_011_101);
    hard_reset();
    for (int k = 0; k < 3; k++) tick9(1'b0, 9'b010_011_101);

    // sll R3,R1 on all configurations
    tick9(1'b1, 9'b110_011_001);
    for (int k = 0; k < 5; k++) tick9(1'b0, 9'b110_011_001);

    // randomized traffic with occasional asynchronous reset
    for (int n = 0; n < 4000; n++) begin
      tick(1'($urandom_range(0, 1)), 9'($urandom), 9'($urandom), 11'($urandom));
      if ($urandom_range(0, 399) == 0) hard_reset();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
Parametrised control FSM for the multicycle bus-based processor. It sequences fetch and execute of mv, mvi, add, sub, or, slt, sll and srl over up to four timesteps. It drives register write-enables, the one-hot bus select, the A/G ALU strobes and the ALU op code. It replaces per-operation result registers with a single A/G pair and an encoded ALU op. It adds an explicit Run start handshake, back-to-back issue, a Busy flag and a shift-disable mode.

Parameters:
NREG, 8, number of general registers; power of 2, minimum 2; REG_AW = $clog2(NREG) derived.
SHIFT_EN, 1, 1 = sll/srl execute; 0 = sll/srl retire as NOP.
IR_W, 3+2*REG_AW (localparam, not overridable), instruction width.

Ports:
Clock  in  1  rising-edge clock
Resetn  in  1  asynchronous, active-low reset
Run  in  1  start request
DIN  in  IR_W  instruction word, low bits of processor data input; {opc[2:0], X, Y}
IRin  out  1  IR write-enable (IR held inside this block)
Rin  out  NREG  one-hot register write-enable
BusSel  out  NREG+2  one-hot bus source; [NREG-1:0]=Rk, [NREG]=G, [NREG+1]=DIN
Ain  out  1  A register write-enable
Gin  out  1  G register write-enable
AluOp  out  3  0=ADD 1=SUB 2=OR 3=SLT 4=SLL 5=SRL
Done  out  1  one-cycle retire pulse
Busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, Resetn=0): state=IDLE, internal IR=0, all outputs 0. A reset mid-instruction abandons it. No Rin is issued after reset.
- All outputs are decoded combinationally from the registered state and IR (Moore). BusSel is all-zero or exactly one-hot. Rin is all-zero or exactly one-hot.
- Inactive outputs are 0. AluOp=0 unless Gin=1.
- States: IDLE, T0, T1, T2, T3.
- IDLE: if Run=1 at the clock edge, go to T0; otherwise stay.
- T0: IRin=1 and IR<=DIN. Go to T1.
- T1, mv: BusSel[Y]=1, Rin[X]=1, Done=1.
- T1, mvi: BusSel[NREG+1]=1, Rin[X]=1, Done=1. The environment presents the immediate on the processor data input in this cycle.
- T1, add/sub/or/slt/sll/srl: BusSel[X]=1, Ain=1. Go to T2.
- T1, sll/srl with SHIFT_EN=0: Done=1 only.
- T2: BusSel[Y]=1, Gin=1, AluOp per opcode. Go to T3.
- T3: BusSel[NREG]=1, Rin[X]=1, Done=1.
- Done cycle: if Run=1, next state is T0 (no IDLE bubble); otherwise IDLE.
- Run is sampled only in IDLE and in Done cycles and is ignored elsewhere.
- Latency from Run sampled to Done: 2 cycles for mv, mvi and the SHIFT_EN=0 NOP; 4 cycles for ALU ops.
- X==Y is legal. mv Rx,Rx asserts BusSel[X] and Rin[X] together.
- IR holds its value until the next T0.

Decomposition:
- Package proc_pkg holds:
  - opcode localparams OP_MV..OP_SRL;
  - ALU_ADD..ALU_SRL encodings;
  - state enum;
  - BusSel index offsets G_IDX=NREG and DIN_IDX=NREG+1, expressed as functions of NREG.
- One sub-module: onehot_dec #(.AW), an enable-gated AW-to-2^AW decoder. It is instantiated twice, for X and Y.

Test Plan:
- NREG=8, Resetn released, DIN=9'b000_010_101, Run=1 for one cycle -> next cycle IRin=1; following cycle BusSel=10'h020, Rin=8'h04, Done=1; then IDLE with Busy=0.
- mvi with DIN=9'b001_111_000 -> T1 shows BusSel=10'h200, Rin=8'h80, Done=1.
- sub with DIN=9'b011_001_011 -> T1 BusSel=10'h002 with Ain=1; T2 BusSel=10'h008, Gin=1, AluOp=1; T3 BusSel=10'h100, Rin=8'h02, Done=1.
- Run held high across add then mv -> cycle after the add's Done has IRin=1 and Busy never drops.
- Resetn pulsed low during T2 of an add -> all outputs 0 immediately, state IDLE, Rin stays 0 through the following cycles until a new Run.
- SHIFT_EN=0, DIN=9'b110_011_001 -> T1 Done=1 with Rin=0, BusSel=0, Ain=0. Repeat with SHIFT_EN=1 and NREG=16 (IR_W=11), srl R9,R2 -> T2 AluOp=5, T3 Rin=16'h0200.
